// File: rtl/isa_cmd_queue_pkg.sv
// Shared definitions for the ISA host command queue.
// Holds the control_out bit positions, the issue FSM state encoding,
// the default I/O address width and a helper that forms the request word.
package isa_cmd_queue_pkg;

  localparam int CTRL_READ_BIT  = 0;
  localparam int CTRL_WRITE_BIT = 1;
  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

  // Request word for a head entry: exactly one of the read/write bits is set.
  function automatic logic [7:0] ctrl_word(input logic is_write);
    logic [7:0] word;
    word = 8'h00;
    if (is_write) begin
      word[CTRL_WRITE_BIT] = 1'b1;
    end else begin
      word[CTRL_READ_BIT] = 1'b1;
    end
    return word;
  endfunction

endpackage

// File: rtl/isa_cmd_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO storing host bus commands.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   push, push_data   write strobe and entry; ignored while full
//   pop               remove head entry; ignored while empty
//   head_data         entry at the head (valid while not empty)
//   full, empty       occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  // A push while full is dropped even if the head leaves this same cycle.
  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty_s;

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign full      = full_s;
  assign empty     = empty_s;

endmodule

// File: rtl/isa_cmd_queue.sv
// isa_cmd_queue: buffers host ISA I/O commands and hands them one at a
// time to an external bus sequencer, capturing read data on the way back.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   host_wr_en/is_write/addr/wdata command push from the host
//   host_full                      queue full, pushes dropped
//   control_out                    request word (bit0 read, bit1 write)
//   bus_addr, bus_wdata            head command, latched at issue
//   control_reset                  active-low end-of-cycle from sequencer
//   data_load, isa_data_in         active-low read strobe and data bus
//   rd_data, rd_valid, rd_ack      captured read byte handshake
//   rd_overrun                     sticky lost-read indicator
module isa_cmd_queue
  import isa_cmd_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_en,
  input  logic              host_is_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_full,
  output logic [7:0]        control_out,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              control_reset,
  input  logic              data_load,
  input  logic [7:0]        isa_data_in,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ack,
  output logic              rd_overrun
);

  localparam int ENTRY_W = 1 + ADDR_W + 8;

  logic [ENTRY_W-1:0] fifo_head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               head_is_write_s;
  logic [ADDR_W-1:0]  head_addr_s;
  logic [7:0]         head_wdata_s;
  issue_state_e       state_r;
  issue_state_e       state_nx_s;
  logic               pop_s;
  logic               load_s;
  logic               capture_s;
  logic [7:0]         control_out_r;
  logic [ADDR_W-1:0]  bus_addr_r;
  logic [7:0]         bus_wdata_r;
  logic [7:0]         rd_data_r;
  logic               rd_valid_r;
  logic               rd_overrun_r;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (host_wr_en),
    .push_data ({host_is_write, host_addr, host_wdata}),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign head_is_write_s = fifo_head_s[ENTRY_W-1];
  assign head_addr_s     = fifo_head_s[ENTRY_W-2:8];
  assign head_wdata_s    = fifo_head_s[7:0];

  // Issue FSM next state: start on a non-empty queue, finish on control_reset low.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_nx_s = ST_ISSUE;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!control_reset) begin
          state_nx_s = ST_IDLE;
          pop_s      = 1'b1;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request word and head copy; latched on entry to ISSUE so they stay stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      control_out_r <= 8'h00;
      bus_addr_r    <= {ADDR_W{1'b0}};
      bus_wdata_r   <= 8'h00;
    end else if (load_s) begin
      control_out_r <= ctrl_word(head_is_write_s);
      bus_addr_r    <= head_addr_s;
      bus_wdata_r   <= head_wdata_s;
    end else if (pop_s) begin
      control_out_r <= 8'h00;
    end
  end

  // Only a read request in flight may capture the data bus.
  assign capture_s = (state_r == ST_ISSUE) && control_out_r[CTRL_READ_BIT] && !data_load;

  // Read byte capture and host handshake; overrun is sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_r    <= 8'h00;
      rd_valid_r   <= 1'b0;
      rd_overrun_r <= 1'b0;
    end else if (capture_s) begin
      rd_data_r  <= isa_data_in;
      rd_valid_r <= 1'b1;
      if (rd_valid_r && !rd_ack) begin
        rd_overrun_r <= 1'b1;
      end
    end else if (rd_ack) begin
      rd_valid_r <= 1'b0;
    end
  end

  assign host_full   = fifo_full_s;
  assign control_out = control_out_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign rd_overrun  = rd_overrun_r;

endmodule

// File: tb/tb_isa_cmd_queue.sv
// Randomized scoreboard bench for isa_cmd_queue.
// The driver applies random host pushes and sequencer activity on the
// falling edge, advances a queue-based reference model and pushes the
// expected post-edge status into a scoreboard; a monitor pops and compares
// one entry after each rising edge, and checks every issued command
// against the accepted-command queue in order.
module tb_isa_cmd_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int NCYC   = 2500;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } cmd_t;

  typedef struct packed {
    logic [7:0]        ctrl;
    logic              full;
    logic              rdv;
    logic [7:0]        rdd;
    logic              ovr;
    logic              chk_bus;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } snap_t;

  logic              clk;
  logic              reset;
  logic              host_wr_en;
  logic              host_is_write;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_full;
  logic [7:0]        control_out;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              control_reset;
  logic              data_load;
  logic [7:0]        isa_data_in;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_ack;
  logic              rd_overrun;

  int vectors = 0;
  int miscompares = 0;

  snap_t exp_q[$];
  cmd_t  cmd_exp_q[$];

  isa_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_wr_en    (host_wr_en),
    .host_is_write (host_is_write),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_full     (host_full),
    .control_out   (control_out),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .control_reset (control_reset),
    .data_load     (data_load),
    .isa_data_in   (isa_data_in),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ack        (rd_ack),
    .rd_overrun    (rd_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare status after every rising edge and each newly issued command.
  initial begin
    snap_t      s;
    cmd_t       c;
    logic [7:0] prev_ctrl;
    prev_ctrl = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("control_out", 32'(control_out), 32'(s.ctrl));
        check("host_full",   32'(host_full),   32'(s.full));
        check("rd_valid",    32'(rd_valid),    32'(s.rdv));
        check("rd_data",     32'(rd_data),     32'(s.rdd));
        check("rd_overrun",  32'(rd_overrun),  32'(s.ovr));
        if (s.chk_bus) begin
          check("bus_addr",  32'(bus_addr),  32'(s.addr));
          check("bus_wdata", 32'(bus_wdata), 32'(s.wdata));
        end
      end
      if (prev_ctrl == 8'h00 && control_out != 8'h00) begin
        if (cmd_exp_q.size() == 0) begin
          check("issue_unexpected", 32'(control_out), 32'd0);
        end else begin
          c = cmd_exp_q.pop_front();
          check("issue_type", 32'(control_out), c.w ? 32'h2 : 32'h1);
          check("issue_addr", 32'(bus_addr),    32'(c.a));
          check("issue_data", 32'(bus_wdata),   32'(c.d));
        end
      end
      prev_ctrl = control_out;
    end
  end

  // Driver and reference model: the model state describes the DUT after the next rising edge.
  initial begin
    cmd_t       mq[$];
    cmd_t       c;
    snap_t      s;
    bit         m_issuing;
    logic [7:0] m_rdd;
    bit         m_rdv;
    bit         m_ovr;
    bit         do_rst;
    bit         accept;
    bit         capture;
    bit         pop;
    int         push_pct;
    int         pop_pct;

    m_issuing = 0; m_rdd = 8'h00; m_rdv = 0; m_ovr = 0;
    reset = 1'b0; host_wr_en = 1'b0; host_is_write = 1'b0; host_addr = '0;
    host_wdata = 8'h00; control_reset = 1'b1; data_load = 1'b1;
    isa_data_in = 8'h00; rd_ack = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc < 500)       begin push_pct = 30; pop_pct = 50; end
      else if (cyc < 1000) begin push_pct = 90; pop_pct = 5;  end
      else if (cyc < 2000) begin push_pct = 60; pop_pct = 60; end
      else                 begin push_pct = 10; pop_pct = 80; end

      do_rst        = (cyc < 2) || ($urandom_range(0, 199) == 0);
      c.w           = 1'($urandom_range(0, 1));
      c.a           = ADDR_W'($urandom);
      c.d           = 8'($urandom);
      host_wr_en    = ($urandom_range(0, 99) < push_pct);
      host_is_write = c.w;
      host_addr     = c.a;
      host_wdata    = c.d;
      if (m_issuing) control_reset = !($urandom_range(0, 99) < pop_pct);
      else           control_reset = ($urandom_range(0, 3) != 0);
      data_load     = ($urandom_range(0, 2) != 0);
      isa_data_in   = 8'($urandom);
      rd_ack        = ($urandom_range(0, 3) == 0);
      reset         = !do_rst;

      s = '0;
      if (do_rst) begin
        mq.delete();
        cmd_exp_q.delete();
        m_issuing = 0; m_rdd = 8'h00; m_rdv = 0; m_ovr = 0;
        s.chk_bus = 1'b1;
      end else begin
        accept  = host_wr_en && (mq.size() < DEPTH);
        capture = m_issuing && !mq[0].w && !data_load;
        pop     = m_issuing && !control_reset;
        if (capture) begin
          if (m_rdv && !rd_ack) m_ovr = 1;
          m_rdd = isa_data_in;
          m_rdv = 1;
        end else if (rd_ack) begin
          m_rdv = 0;
        end
        if (pop) begin
          void'(mq.pop_front());
          m_issuing = 0;
        end else if (!m_issuing && mq.size() > 0) begin
          m_issuing = 1;
        end
        if (accept) begin
          mq.push_back(c);
          cmd_exp_q.push_back(c);
        end
        if (m_issuing) begin
          s.ctrl    = mq[0].w ? 8'h02 : 8'h01;
          s.chk_bus = 1'b1;
          s.addr    = mq[0].a;
          s.wdata   = mq[0].d;
        end
      end
      s.full = (mq.size() == DEPTH);
      s.rdv  = m_rdv;
      s.rdd  = m_rdd;
      s.ovr  = m_ovr;
      exp_q.push_back(s);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isa_cmd_queue.md
ISA_CMD_QUEUE -- requirements
Module: isa_cmd_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queued host bus commands (power of two, 2..16).
REQ-002 Parameter: ADDR_W, 10, ISA I/O address width.
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: host_wr_en  input  1  push strobe, one command per high cycle.
REQ-006 Port: host_is_write  input  1  1 = ISA I/O write, 0 = ISA I/O read.
REQ-007 Port: host_addr  input  ADDR_W  I/O address of pushed command.
REQ-008 Port: host_wdata  input  8  write data of pushed command (don't-care for reads).
REQ-009 Port: host_full  output  1  queue holds DEPTH entries; pushes ignored.
REQ-010 Port: control_out  output  8  request word to bus sequencer; bit0 = read request, bit1 = write request, bits7:2 = 0.
REQ-011 Port: bus_addr  output  ADDR_W  address of head entry.
REQ-012 Port: bus_wdata  output  8  write data of head entry.
REQ-013 Port: control_reset  input  1  active-low end-of-cycle pulse from bus sequencer.
REQ-014 Port: data_load  input  1  active-low data strobe from bus sequencer.
REQ-015 Port: isa_data_in  input  8  ISA data bus value during reads.
REQ-016 Port: rd_data  output  8  last captured read byte.
REQ-017 Port: rd_valid  output  1  rd_data unconsumed.
REQ-018 Port: rd_ack  input  1  host consumes rd_data.
REQ-019 Port: rd_overrun  output  1  sticky: unconsumed read byte was overwritten.

Function
REQ-020 Push: when host_wr_en=1 and host_full=0, {host_is_write, host_addr, host_wdata} SHALL be written at tail; when host_full=1 the push SHALL be dropped with no state change, even if a pop occurs the same cycle.
REQ-021 Occupancy count SHALL be 0..DEPTH; simultaneous accepted push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 bus_addr/bus_wdata SHALL reflect the head entry and be stable for the whole ISSUE state.
REQ-023 Issue FSM states: IDLE, ISSUE.
REQ-024 IDLE: control_out=0; if count>0, next state ISSUE.
REQ-025 ISSUE: control_out bit0=1 for a read head, bit1=1 for a write head, never both; held registered until control_reset=0 is sampled.
REQ-026 On sampling control_reset=0 in ISSUE: pop head, return to IDLE, control_out=0 from the next cycle; minimum one IDLE cycle between commands.
REQ-027 control_reset=0 sampled in IDLE SHALL be ignored.
REQ-028 Read capture: in ISSUE with a read head and data_load=0, isa_data_in SHALL be registered into rd_data and rd_valid set the next cycle; data_load=0 during a write head SHALL be ignored.
REQ-029 rd_ack=1 with no capture SHALL clear rd_valid next cycle; capture and rd_ack the same cycle SHALL leave rd_valid=1 with new data and no overrun.
REQ-030 Capture while rd_valid=1 without rd_ack SHALL overwrite rd_data and set rd_overrun, which stays set until reset.

Reset
REQ-031 reset=0 at a clk edge SHALL: empty queue, FSM to IDLE, control_out=0, bus_addr=0, bus_wdata=0, host_full=0, rd_data=0, rd_valid=0, rd_overrun=0.
REQ-032 Reset mid-ISSUE SHALL discard the in-flight command without pop completion or read capture.

Structure
REQ-033 Shared package SHALL hold CTRL_READ_BIT=0, CTRL_WRITE_BIT=1, FSM state encoding, default ADDR_W.
REQ-034 Storage SHALL be one sub-module, sync_fifo, parameterised by width and DEPTH; FSM and read capture stay in isa_cmd_queue.

Verification
REQ-035 Push write 0x220/0x5A -> control_out=0x02, bus_addr=0x220, bus_wdata=0x5A until control_reset pulse; then 0x00, count 0.
REQ-036 Push read 0x22A, isa_data_in=0xAA at data_load=0 -> rd_data=0xAA, rd_valid=1; rd_ack -> rd_valid=0, rd_overrun=0.
REQ-037 Push 5 commands with DEPTH=4, no sequencer activity -> host_full=1 after 4th, 5th dropped; 4 pops yield entries in order.
REQ-038 Two reads back-to-back, no rd_ack -> rd_data = second byte, rd_overrun=1; capture with simultaneous rd_ack -> rd_overrun unchanged.
REQ-039 reset=0 asserted during ISSUE of a read -> next cycle control_out=0, queue empty, rd_valid=0; later data_load=0 ignored.
REQ-040 Write head with data_load=0 -> rd_valid stays 0, rd_data unchanged.
